// File: rtl/midori64_unmask_serial_pkg.sv
// Shared constants and FSM encoding for the Midori64 threshold-implementation unmasking stage.
// Imported by midori64_unmask_serial and its nibble recombiner.
package midori64_unmask_serial_pkg;

    localparam int MIDORI_W          = 64;
    localparam int MIDORI_NIB_W      = 4;
    localparam int MIDORI_NUM_NIB    = MIDORI_W / MIDORI_NIB_W;
    localparam int MIDORI_NUM_SHARES = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMBINE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/midori64_unmask_serial_nibble.sv
// Single-nibble share recombiner: the only place where all three shares meet,
// and only ever on one registered nibble slice at a time.
module midori64_unmask_serial_nibble
    import midori64_unmask_serial_pkg::*;
#(
    parameter int NIB_W = MIDORI_NIB_W
) (
    input  logic [NIB_W-1:0] in_1,
    input  logic [NIB_W-1:0] in_2,
    input  logic [NIB_W-1:0] in_3,
    output logic [NIB_W-1:0] out
);

    assign out = in_1 ^ in_2 ^ in_3;

endmodule

// File: rtl/midori64_unmask_serial.sv
// Serial 3-share unmasking of the Midori64 state, one nibble per cycle, valid/ready on both sides.
// Build option UNMASK_ZEROIZE_EN: clear share registers after the last nibble and y after the output handshake.
module midori64_unmask_serial
    import midori64_unmask_serial_pkg::*;
#(
    parameter int WIDTH = MIDORI_W,
    parameter int NIB_W = MIDORI_NIB_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] x2,
    input  logic [WIDTH-1:0] x3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             busy
);

    // WIDTH must be a multiple of NIB_W; NUM_NIB is derived, not a parameter.
    localparam int NUM_NIB = WIDTH / NIB_W;
    localparam int CNT_W   = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NUM_NIB - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_s3;
    logic [WIDTH-1:0] r_y;
    logic             r_out_valid;
    logic             r_in_ready;
    logic             r_busy;

    logic [NIB_W-1:0] w_nib_1;
    logic [NIB_W-1:0] w_nib_2;
    logic [NIB_W-1:0] w_nib_3;
    logic [NIB_W-1:0] w_nib_y;

    // Slices come straight from registers so no glitch can expose whole shares together.
    assign w_nib_1 = r_s1[r_cnt*NIB_W +: NIB_W];
    assign w_nib_2 = r_s2[r_cnt*NIB_W +: NIB_W];
    assign w_nib_3 = r_s3[r_cnt*NIB_W +: NIB_W];

    midori64_unmask_serial_nibble #(
        .NIB_W (NIB_W)
    ) u_nibble (
        .in_1 (w_nib_1),
        .in_2 (w_nib_2),
        .in_3 (w_nib_3),
        .out  (w_nib_y)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_s1        <= '0;
            r_s2        <= '0;
            r_s3        <= '0;
            r_y         <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (in_valid && r_in_ready) begin
                        r_s1       <= x1;
                        r_s2       <= x2;
                        r_s3       <= x3;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_COMBINE;
                    end
                end
                ST_COMBINE: begin
                    r_y[r_cnt*NIB_W +: NIB_W] <= w_nib_y;
                    if (r_cnt == LAST_NIB) begin
                        r_cnt       <= '0;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
`ifdef UNMASK_ZEROIZE_EN
                        r_s1        <= '0;
                        r_s2        <= '0;
                        r_s3        <= '0;
`endif
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    // in_ready only rises after the state is back in IDLE.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
`ifdef UNMASK_ZEROIZE_EN
                        r_y         <= '0;
`endif
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cnt       <= '0;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign y         = r_y;

endmodule

// File: tb/tb_midori64_unmask_serial.sv
// Scoreboard bench for midori64_unmask_serial: expected words queued at capture, compared at the output handshake.
// Honours UNMASK_ZEROIZE_EN for the register-clearing expectations.
module tb_midori64_unmask_serial;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] x1;
    logic [63:0] x2;
    logic [63:0] x3;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] y;
    logic        busy;

    int          n_chk;
    int          n_fail;
    int          cyc;
    int          cap_cyc;
    logic        prev_ov;
    logic [63:0] exp_q[$];

    midori64_unmask_serial dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x1        (x1),
        .x2        (x2),
        .x3        (x3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Scoreboard: push at the capture edge, pop at the output handshake edge.
    initial begin
        prev_ov = 1'b0;
        cap_cyc = 0;
    end
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            exp_q.push_back(x1 ^ x2 ^ x3);
            cap_cyc = cyc;
        end
        if (rst_n && out_valid && !prev_ov)
            chk("latency", 64'(cyc - cap_cyc), 64'd17);
        if (rst_n && out_valid && out_ready) begin
            chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0)
                chk("sb_y", y, exp_q.pop_front());
        end
        prev_ov = out_valid;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        chk("tmo_in_ready", 64'(in_ready), 64'd1);
        x1       = a;
        x2       = b;
        x3       = c;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_out_valid();
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            step();
            n++;
        end
        chk("tmo_out_valid", 64'(out_valid), 64'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            step();
            n++;
        end
        chk("tmo_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] w;
        logic [63:0] ta[4];
        logic [63:0] tb[4];
        logic [63:0] tc[4];
        int          n;
        int          caps;
        int          last_cap;

        n_chk     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x1        = '0;
        x2        = '0;
        x3        = '0;

        // Reset state
        repeat (3) step();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_y", y, 64'd0);
        rst_n = 1'b1;

        // Test 1 / 6: plain word in x1
        out_ready = 1'b1;
        send(64'h0123456789ABCDEF, 64'd0, 64'd0);
        wait_out_valid();
`ifdef UNMASK_ZEROIZE_EN
        chk("zero_s1", dut.r_s1, 64'd0);
        chk("zero_s2", dut.r_s2, 64'd0);
        chk("zero_s3", dut.r_s3, 64'd0);
`else
        chk("keep_s1", dut.r_s1, 64'h0123456789ABCDEF);
        chk("keep_s2", dut.r_s2, 64'd0);
`endif
        wait_idle();
        chk("post_hs_in_ready", 64'(in_ready), 64'd1);
`ifdef UNMASK_ZEROIZE_EN
        chk("post_hs_y", y, 64'd0);
`else
        chk("post_hs_y", y, 64'h0123456789ABCDEF);
`endif

        // Test 2: random masks around a fixed secret, busy span
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        send(a, b, a ^ b ^ 64'hCAFEBABEDEADBEEF);
        n = 0;
        while (busy && n < 100) begin
            n++;
            step();
        end
        chk("busy_span", 64'(n), 64'd17);

        // Test 3: output stall with a competing triple
        out_ready = 1'b0;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        w = 64'h5A5A_0F0F_1234_FEDC;
        send(a, b, a ^ b ^ w);
        wait_out_valid();
        for (int i = 0; i < 10; i++) begin
            chk("stall_y", y, w);
            chk("stall_ov", 64'(out_valid), 64'd1);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            if (i == 2) begin
                x1       = {$urandom, $urandom};
                x2       = {$urandom, $urandom};
                x3       = {$urandom, $urandom};
                in_valid = 1'b1;
            end
            if (i == 7) in_valid = 1'b0;
            step();
        end
        out_ready = 1'b1;
        step();
        chk("stall_release_in_ready", 64'(in_ready), 64'd1);
        chk("stall_release_ov", 64'(out_valid), 64'd0);
        step();
        step();
        chk("stall_no_capture", 64'(busy), 64'd0);

        // Test 4: reset while combining at nibble 7
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1111_2222_3333_4444, 64'd0);
        repeat (7) step();
        rst_n = 1'b0;
        step();
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_y", y, 64'd0);
        exp_q.delete();
        rst_n = 1'b1;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        send(a, b, 64'h8000_0000_0000_0001);
        wait_idle();

        // Test 5: back-to-back triples with both handshakes held high
        for (int i = 0; i < 4; i++) begin
            ta[i] = {$urandom, $urandom};
            tb[i] = {$urandom, $urandom};
            tc[i] = {$urandom, $urandom};
        end
        x1       = ta[0];
        x2       = tb[0];
        x3       = tc[0];
        in_valid = 1'b1;
        caps     = 0;
        last_cap = 0;
        n        = 0;
        while (caps < 4 && n < 200) begin
            @(negedge clk);
            n++;
            if (in_ready) begin
                if (caps > 0) chk("b2b_period", 64'(cyc - last_cap), 64'd18);
                last_cap = cyc;
                caps++;
                step();
                if (caps < 4) begin
                    x1 = ta[caps];
                    x2 = tb[caps];
                    x3 = tc[caps];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        chk("b2b_count", 64'(caps), 64'd4);
        wait_idle();
        step();
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
